spi_slave_responder: RTL

SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

---
 rtl/spi_slave_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave with one-deep TX holding register and RX data register.
// SPI pins are oversampled by the system clock through 2-flop synchronizers.
module spi_slave_responder #(
  parameter int DATA_W = 8
) (
  input  logic              spi_wb_clk_i,
  input  logic              spi_wb_rst_i,
  input  logic              sck_i,
  input  logic              ss_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ack_i,
  output logic              rx_overrun_o,
  output logic              tx_underrun_o
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state_q, state_d;

  logic [2:0]        sck_sh;
  logic [2:0]        ss_sh;
  logic [1:0]        mosi_sh;
  logic [CW-1:0]     cnt_q;
  logic              started_q;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] hold_q;
  logic              hold_full_q;

  logic sck_rise, sck_fall, ss_fall, ss_rise, mosi_s;
  logic start, abort, in_shift, bit_rise, bit_fall;
  logic byte_done, load, wr;
  logic [DATA_W-1:0] rx_next;

  // bit [0],[1] are the synchronizer, [2] holds the previous value for edges
  always_ff @(posedge spi_wb_clk_i or posedge spi_wb_rst_i) begin
    if (spi_wb_rst_i) begin
      sck_sh  <= '0;
      ss_sh   <= '1;
      mosi_sh <= '0;
    end else begin
      sck_sh  <= {sck_sh[1:0], sck_i};
      ss_sh   <= {ss_sh[1:0], ss_n_i};
      mosi_sh <= {mosi_sh[0], mosi_i};
    end
  end

  assign sck_rise = sck_sh[1] & ~sck_sh[2];
  assign sck_fall = ~sck_sh[1] & sck_sh[2];
  assign ss_fall  = ~ss_sh[1] & ss_sh[2];
  assign ss_rise  = ss_sh[1] & ~ss_sh[2];
  assign mosi_s   = mosi_sh[1];

  always_ff @(posedge spi_wb_clk_i or posedge spi_wb_rst_i) begin
    if (spi_wb_rst_i) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (ss_fall) state_d = SHIFT;
      SHIFT: if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign start     = (state_q == IDLE) && ss_fall;
  assign abort     = (state_q == SHIFT) && ss_rise;
  assign in_shift  = (state_q == SHIFT) && !ss_rise;
  assign bit_rise  = in_shift && sck_rise;
  assign bit_fall  = in_shift && sck_fall;
  assign byte_done = bit_rise && (cnt_q == LAST);
  assign load      = start
                   || (bit_fall && (cnt_q == '0) && started_q);
  assign wr        = tx_valid_i && tx_ready_o;
  assign rx_next   = DATA_W'({rx_sh, mosi_s});

  assign tx_ready_o = !hold_full_q;
  assign miso_oe    = (state_q == SHIFT);
  assign miso_o     = (state_q == SHIFT) && tx_sh[DATA_W-1];

  always_ff @(posedge spi_wb_clk_i or posedge spi_wb_rst_i) begin
    if (spi_wb_rst_i) begin
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      tx_sh         <= '0;
      tx_underrun_o <= 1'b0;
    end else begin
      if (wr) hold_q <= tx_data_i;
      // a write never coincides with a full-register load
      if (wr)        hold_full_q <= 1'b1;
      else if (load) hold_full_q <= 1'b0;
      tx_underrun_o <= load && !hold_full_q;
      if (load)
        tx_sh <= hold_full_q ? hold_q : '0;
      else if (abort)
        tx_sh <= '0;
      else if (bit_fall && (cnt_q != '0))
        tx_sh <= tx_sh << 1;
    end
  end

  always_ff @(posedge spi_wb_clk_i or posedge spi_wb_rst_i) begin
    if (spi_wb_rst_i) begin
      cnt_q     <= '0;
      started_q <= 1'b0;
      rx_sh     <= '0;
    end else if (start || abort) begin
      cnt_q     <= '0;
      started_q <= 1'b0;
      rx_sh     <= '0;
    end else if (bit_rise) begin
      cnt_q     <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      started_q <= 1'b1;
      rx_sh     <= rx_next;
    end
  end

  always_ff @(posedge spi_wb_clk_i or posedge spi_wb_rst_i) begin
    if (spi_wb_rst_i) begin
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else if (byte_done) begin
      rx_data_o    <= rx_next;
      rx_valid_o   <= 1'b1;
      rx_overrun_o <= rx_ack_i ? 1'b0 : (rx_overrun_o | rx_valid_o);
    end else if (rx_ack_i) begin
      rx_valid_o   <= 1'b0;
      rx_overrun_o <= 1'b0;
    end
  end

endmodule
